newton_rsqrt_iter: RTL

Parametrised, iterative Newton-Raphson refinement unit for FP32 inverse square root. It replaces the fixed single-step, free-running refinement chain. It adds a valid/ready handshake, a per-transaction iteration count, special-value handling and a result hold under backpressure. It sits between the seed generator and the downstream result consumer, with one shared multiplier and one subtractor sequenced by an FSM.

---
 rtl/newton_rsqrt_iter.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/newton_rsqrt_iter.sv
// Iterative Newton-Raphson refinement of an FP32 inverse square root (one multiplier, one subtractor).
// Define NEWTON_RSQRT_SEED_EN to derive the seed internally instead of taking it from y0_in.
module newton_rsqrt_iter #(
    parameter  int MAX_ITER = 3,
    localparam int ITER_W   = $clog2(MAX_ITER + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       x_in,
    input  logic [31:0]       y0_in,
    input  logic [ITER_W-1:0] iter_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       y_out,
    output logic [ITER_W-1:0] iter_done
);

    typedef enum logic [2:0] {IDLE, MUL_A, MUL_B, SUB, MUL_C, DONE} state_t;

    localparam logic [ITER_W-1:0] MAX_ITER_V   = ITER_W'(MAX_ITER);
    localparam logic [31:0]       QNAN         = 32'h7FC0_0000;
    localparam logic [31:0]       PINF         = 32'h7F80_0000;
    localparam logic [31:0]       THREE_HALVES = 32'h3FC0_0000;

    // Truncating FP32 multiply; denormals flush to signed zero, overflow saturates to Inf.
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic              sgn;
        logic [47:0]       prod;
        logic signed [9:0] e;
        logic [22:0]       frac;
        sgn = a[31] ^ b[31];
        if ((a[30:23] == 8'hFF && a[22:0] != 23'd0) || (b[30:23] == 8'hFF && b[22:0] != 23'd0))
            return QNAN;
        if (a[30:23] == 8'hFF || b[30:23] == 8'hFF)
            return (a[30:23] == 8'd0 || b[30:23] == 8'd0) ? QNAN : {sgn, 8'hFF, 23'd0};
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0)
            return {sgn, 31'd0};
        prod = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e    = 10'(a[30:23]) + 10'(b[30:23]) - 10'sd127;
        if (prod[47]) begin
            frac = prod[46:24];
            e    = e + 10'sd1;
        end else begin
            frac = prod[45:23];
        end
        if (e >= 10'sd255) return {sgn, 8'hFF, 23'd0};
        if (e <= 10'sd0)   return {sgn, 31'd0};
        return {sgn, e[7:0], frac};
    endfunction

    // Truncating FP32 add with guard/round/sticky bits so subtraction truncates the exact result.
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0]       big;
        logic [31:0]       sml;
        logic [26:0]       mb;
        logic [26:0]       ms;
        logic [26:0]       diff;
        logic [27:0]       sum;
        logic [7:0]        d;
        logic              sticky;
        logic              found;
        logic signed [9:0] e;
        int                lz;
        if ((a[30:23] == 8'hFF && a[22:0] != 23'd0) || (b[30:23] == 8'hFF && b[22:0] != 23'd0))
            return QNAN;
        if (a[30:23] == 8'hFF && b[30:23] == 8'hFF) return (a[31] == b[31]) ? a : QNAN;
        if (a[30:23] == 8'hFF) return a;
        if (b[30:23] == 8'hFF) return b;
        if (a[30:23] == 8'd0 && b[30:23] == 8'd0) return {a[31] & b[31], 31'd0};
        if (a[30:23] == 8'd0) return b;
        if (b[30:23] == 8'd0) return a;
        if (a[30:0] >= b[30:0]) begin
            big = a;
            sml = b;
        end else begin
            big = b;
            sml = a;
        end
        d  = big[30:23] - sml[30:23];
        mb = {1'b1, big[22:0], 3'b000};
        ms = {1'b1, sml[22:0], 3'b000};
        if (d >= 8'd27) begin
            sticky = 1'b1;
            ms     = 27'd0;
        end else begin
            sticky = |(ms & ((27'd1 << d) - 27'd1));
            ms     = ms >> d;
        end
        ms[0] = ms[0] | sticky;
        e     = 10'(big[30:23]);
        if (big[31] == sml[31]) begin
            sum = 28'(mb) + 28'(ms);
            if (sum[27]) begin
                diff = sum[27:1];
                e    = e + 10'sd1;
            end else begin
                diff = sum[26:0];
            end
        end else begin
            diff = mb - ms;
            if (diff == 27'd0) return 32'd0;
            lz    = 0;
            found = 1'b0;
            for (int i = 26; i >= 0; i--) begin
                if (!found) begin
                    if (diff[i]) found = 1'b1;
                    else         lz    = lz + 1;
                end
            end
            diff = diff << lz;
            e    = e - 10'(lz);
        end
        if (e >= 10'sd255) return {big[31], 8'hFF, 23'd0};
        if (e <= 10'sd0)   return {big[31], 31'd0};
        return {big[31], e[7:0], diff[25:3]};
    endfunction

    state_t            state_q, state_d;
    logic [31:0]       x_h_q, x_h_d;
    logic [31:0]       y_q, y_d;
    logic [31:0]       t_q, t_d;
    logic [ITER_W-1:0] cnt_q, cnt_d;
    logic [ITER_W-1:0] iter_q, iter_d;

    logic [31:0]       seed;
    logic [ITER_W-1:0] iter_clamped;
    logic [ITER_W-1:0] cnt_inc;
    logic [31:0]       mul_a;
    logic [31:0]       mul_b;
    logic [31:0]       mul_res;
    logic [31:0]       sub_res;
    logic              x_nan;
    logic              x_zero;

`ifdef NEWTON_RSQRT_SEED_EN
    assign seed = 32'h5F37_59DF - {1'b0, x_in[31:1]};
`else
    assign seed = y0_in;
`endif

    assign iter_clamped = (iter_in > MAX_ITER_V) ? MAX_ITER_V : iter_in;
    assign cnt_inc      = cnt_q + ITER_W'(1);
    assign x_nan        = (x_in[30:23] == 8'hFF) && (x_in[22:0] != 23'd0);
    assign x_zero       = (x_in[30:23] == 8'd0);

    // The single multiplier is steered by state: xh*y, t*y, then y*t.
    always_comb begin
        mul_a = t_q;
        mul_b = y_q;
        if (state_q == MUL_A) mul_a = x_h_q;
        if (state_q == MUL_C) begin
            mul_a = y_q;
            mul_b = t_q;
        end
    end

    assign mul_res = fp_mul(mul_a, mul_b);
    assign sub_res = fp_add(THREE_HALVES, {~t_q[31], t_q[30:0]});

    always_comb begin
        state_d = state_q;
        x_h_d   = x_h_q;
        y_d     = y_q;
        t_d     = t_q;
        cnt_d   = cnt_q;
        iter_d  = iter_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    cnt_d   = '0;
                    state_d = DONE;
                    if (x_nan || (x_in[31] && !x_zero)) begin
                        y_d = QNAN;
                    end else if (x_zero) begin
                        y_d = PINF;
                    end else if (x_in[30:23] == 8'hFF) begin
                        y_d = 32'd0;
                    end else begin
                        y_d     = seed;
                        iter_d  = iter_clamped;
                        x_h_d   = (x_in[30:23] == 8'd1) ? {x_in[31], 31'd0}
                                                       : {x_in[31], x_in[30:23] - 8'd1, x_in[22:0]};
                        if (iter_clamped != '0) state_d = MUL_A;
                    end
                end
            end
            MUL_A: begin
                t_d     = mul_res;
                state_d = MUL_B;
            end
            MUL_B: begin
                t_d     = mul_res;
                state_d = SUB;
            end
            SUB: begin
                t_d     = sub_res;
                state_d = MUL_C;
            end
            MUL_C: begin
                y_d     = mul_res;
                cnt_d   = cnt_inc;
                state_d = (cnt_inc < iter_q) ? MUL_A : DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            x_h_q   <= '0;
            y_q     <= '0;
            t_q     <= '0;
            cnt_q   <= '0;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            x_h_q   <= x_h_d;
            y_q     <= y_d;
            t_q     <= t_d;
            cnt_q   <= cnt_d;
            iter_q  <= iter_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign y_out     = y_q;
    assign iter_done = cnt_q;

endmodule
